// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths and accumulator FSM state for the multiplier datapath
package mult_pkg;

  localparam int DEF_PROD_W = 32;
  localparam int DEF_ACC_W  = 40;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_t;

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - unsigned adder that clamps to all-ones and reports the carry-out
module sat_add #(
  parameter int W = 40
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] full;

  assign full  = {1'b0, a} + {1'b0, b};
  assign carry = full[W];
  assign sum   = carry ? {W{1'b1}} : full[W-1:0];

endmodule

// File: rtl/mult_prod_accum.sv
// rtl/mult_prod_accum.sv - sums a frame of multiplier products into a saturating accumulator
module mult_prod_accum
  import mult_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_overflow
);

  acc_state_t       state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum_next;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf;
  logic             ovf_next;
  logic             accept;

  assign in_ready = !clr && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    prod_ext = '0;
    prod_ext[PROD_W-1:0] = in_product;
  end

  // In IDLE the first beat of a frame always starts from zero.
  assign acc_base = (state == ACCUM) ? acc : '0;
  assign cnt_base = (state == ACCUM) ? cnt : '0;
  assign cnt_next = (cnt_base == {CNT_W{1'b1}}) ? cnt_base : cnt_base + 1'b1;
  assign ovf_next = ((state == ACCUM) && ovf) || carry;

  sat_add #(.W(ACC_W)) u_sat_add (
    .a     (acc_base),
    .b     (prod_ext),
    .sum   (sum_next),
    .carry (carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else begin
      if (clr) begin
        state <= IDLE;
        acc   <= '0;
        cnt   <= '0;
        ovf   <= 1'b0;
      end else if (accept) begin
        if (in_last) begin
          state        <= IDLE;
          acc          <= '0;
          cnt          <= '0;
          ovf          <= 1'b0;
          out_sum      <= sum_next;
          out_count    <= cnt_next;
          out_overflow <= ovf_next;
        end else begin
          state <= ACCUM;
          acc   <= sum_next;
          cnt   <= cnt_next;
          ovf   <= ovf_next;
        end
      end

      // A last beat landing in the drain cycle keeps the register full.
      if (accept && in_last) begin
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_prod_accum.sv
// tb/tb_mult_prod_accum.sv - bench for mult_prod_accum at ACC_W=40 and ACC_W=34
module tb_mult_prod_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_product = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, in_ready34;
  logic        out_valid, out_valid34;
  logic [39:0] out_sum;
  logic [33:0] out_sum34;
  logic [7:0]  out_count, out_count34;
  logic        out_overflow, out_overflow34;

  always #5 clk = ~clk;

  mult_prod_accum u_dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_product(in_product), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
    .out_overflow(out_overflow)
  );

  mult_prod_accum #(.ACC_W(34)) u_dut34 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready34),
    .in_product(in_product), .in_last(in_last), .out_valid(out_valid34),
    .out_ready(out_ready), .out_sum(out_sum34), .out_count(out_count34),
    .out_overflow(out_overflow34)
  );

  int total = 0;
  int bad   = 0;

  // Reference: frame kept as a plain running total and beat count.
  localparam longint unsigned MAX40 = 64'h0000_00FF_FFFF_FFFF;
  localparam longint unsigned MAX34 = 64'h0000_0003_FFFF_FFFF;
  longint unsigned f_sum = 0;
  int              f_n = 0;
  logic            m_valid = 1'b0;
  longint unsigned m_sum40 = 0, m_sum34 = 0;
  int              m_cnt = 0;
  logic            m_ovf40 = 1'b0, m_ovf34 = 1'b0;
  logic            last_rdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic rdy;
    if (rst) begin
      f_sum = 0; f_n = 0; m_valid = 0;
      m_sum40 = 0; m_sum34 = 0; m_cnt = 0; m_ovf40 = 0; m_ovf34 = 0;
    end else begin
      rdy = !clr && (!m_valid || out_ready);
      if (clr) begin
        f_sum = 0; f_n = 0;
      end
      if (in_valid && rdy) begin
        f_sum += longint'(in_product);
        f_n++;
        if (in_last) begin
          m_sum40 = (f_sum > MAX40) ? MAX40 : f_sum;
          m_sum34 = (f_sum > MAX34) ? MAX34 : f_sum;
          m_ovf40 = f_sum > MAX40;
          m_ovf34 = f_sum > MAX34;
          m_cnt   = (f_n > 255) ? 255 : f_n;
          m_valid = 1'b1;
          f_sum = 0; f_n = 0;
        end else if (m_valid && out_ready) begin
          m_valid = 1'b0;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic exp_rdy;
    @(negedge clk);
    exp_rdy  = !clr && (!m_valid || out_ready);
    last_rdy = in_ready;
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    chk("in_ready34", {63'd0, in_ready34}, {63'd0, exp_rdy});
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    chk("out_valid34", {63'd0, out_valid34}, {63'd0, m_valid});
    chk("out_sum", {24'd0, out_sum}, m_sum40);
    chk("out_sum34", {30'd0, out_sum34}, m_sum34);
    chk("out_count", {56'd0, out_count}, 64'(m_cnt));
    chk("out_count34", {56'd0, out_count34}, 64'(m_cnt));
    chk("out_overflow", {63'd0, out_overflow}, {63'd0, m_ovf40});
    chk("out_overflow34", {63'd0, out_overflow34}, {63'd0, m_ovf34});
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] p, input logic l,
                       input logic ordy, input logic c);
    in_valid = v; in_product = p; in_last = l; out_ready = ordy; clr = c;
    tick();
  endtask

  typedef struct {
    int          n;
    logic [31:0] p;
    logic [39:0] s40;
    logic [33:0] s34;
    logic [7:0]  cnt;
    logic        o40;
    logic        o34;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{3,   32'd5,          40'd15,            34'd15,           8'd3,   1'b0, 1'b0};
    vecs[1] = '{1,   32'hFFFE_0001,  40'h00_FFFE_0001,  34'h0_FFFE_0001,  8'd1,   1'b0, 1'b0};
    vecs[2] = '{2,   32'hFFFF_FFFF,  40'h01_FFFF_FFFE,  34'h1_FFFF_FFFE,  8'd2,   1'b0, 1'b0};
    vecs[3] = '{300, 32'd1,          40'd300,           34'd300,          8'd255, 1'b0, 1'b0};
    vecs[4] = '{257, 32'hFFFF_FFFF,  40'hFF_FFFF_FFFF,  34'h3_FFFF_FFFF,  8'd255, 1'b1, 1'b1};
    vecs[5] = '{4,   32'hFFFE_0001,  40'h03_FFF8_0004,  34'h3_FFF8_0004,  8'd4,   1'b0, 1'b0};
    vecs[6] = '{5,   32'hFFFE_0001,  40'h04_FFF6_0005,  34'h3_FFFF_FFFF,  8'd5,   1'b0, 1'b1};
    vecs[7] = '{4,   32'd0,          40'd0,             34'd0,            8'd4,   1'b0, 1'b0};

    @(posedge clk); #1;
    model_edge();
    drive(0, 0, 0, 1, 0);
    rst = 1'b0;
    chk("reset_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_sum", {24'd0, out_sum}, 64'd0);
    chk("reset_count", {56'd0, out_count}, 64'd0);
    chk("reset_ovf", {63'd0, out_overflow}, 64'd0);

    // 1, 2, 3 -> 6
    drive(1, 1, 0, 1, 0);
    drive(1, 2, 0, 1, 0);
    drive(1, 3, 1, 1, 0);
    chk("t1_valid", {63'd0, out_valid}, 64'd1);
    chk("t1_sum", {24'd0, out_sum}, 64'd6);
    chk("t1_count", {56'd0, out_count}, 64'd3);
    chk("t1_ovf", {63'd0, out_overflow}, 64'd0);

    for (int i = 0; i < 8; i++) begin
      for (int b = 0; b < vecs[i].n; b++)
        drive(1, vecs[i].p, (b == vecs[i].n - 1), 1, 0);
      chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("vec%0d_sum", i), {24'd0, out_sum}, {24'd0, vecs[i].s40});
      chk($sformatf("vec%0d_sum34", i), {30'd0, out_sum34}, {30'd0, vecs[i].s34});
      chk($sformatf("vec%0d_count", i), {56'd0, out_count}, {56'd0, vecs[i].cnt});
      chk($sformatf("vec%0d_ovf", i), {63'd0, out_overflow}, {63'd0, vecs[i].o40});
      chk($sformatf("vec%0d_ovf34", i), {63'd0, out_overflow34}, {63'd0, vecs[i].o34});
    end

    // Backpressure: result 10 held while out_ready=0
    drive(0, 0, 0, 1, 0);
    drive(1, 4, 0, 0, 0);
    drive(1, 6, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 3, 1, 0, 0);
      chk("t4_blocked", {63'd0, last_rdy}, 64'd0);
      chk("t4_hold_sum", {24'd0, out_sum}, 64'd10);
      chk("t4_hold_valid", {63'd0, out_valid}, 64'd1);
    end
    drive(1, 3, 1, 1, 0);
    chk("t4_rdy_on_drain", {63'd0, last_rdy}, 64'd1);
    chk("t4_new_valid", {63'd0, out_valid}, 64'd1);
    chk("t4_new_sum", {24'd0, out_sum}, 64'd3);
    chk("t4_new_count", {56'd0, out_count}, 64'd1);

    // clr leaves an undrained result alone and aborts the frame
    drive(1, 50, 1, 1, 0);
    drive(0, 0, 0, 0, 1);
    chk("t5_clr_valid", {63'd0, out_valid}, 64'd1);
    chk("t5_clr_sum", {24'd0, out_sum}, 64'd50);
    drive(0, 0, 0, 1, 0);
    drive(1, 10, 0, 1, 0);
    drive(1, 10, 0, 1, 0);
    drive(1, 99, 0, 1, 1);
    chk("t5_clr_rdy", {63'd0, last_rdy}, 64'd0);
    drive(1, 7, 1, 1, 0);
    chk("t5_sum", {24'd0, out_sum}, 64'd7);
    chk("t5_count", {56'd0, out_count}, 64'd1);

    // rst with out_valid=1, then rst mid-frame
    drive(1, 8, 1, 1, 0);
    rst = 1'b1;
    drive(1, 9, 1, 0, 0);
    rst = 1'b0;
    chk("t6_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_sum", {24'd0, out_sum}, 64'd0);
    drive(0, 0, 0, 0, 0);
    chk("t6_rdy", {63'd0, last_rdy}, 64'd1);
    drive(1, 20, 0, 1, 0);
    rst = 1'b1;
    drive(0, 0, 0, 1, 0);
    rst = 1'b0;
    drive(1, 4, 0, 1, 0);
    drive(1, 5, 1, 1, 0);
    chk("t6_sum2", {24'd0, out_sum}, 64'd9);
    chk("t6_count2", {56'd0, out_count}, 64'd2);

    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 255)),
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 29) == 0);
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
